// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
// Recovers the hex digit behind an active-low seven-segment pattern. The
// pattern is synchronised and debounced, then decoded. Each newly settled
// digit is offered once on a valid/ready handshake. Patterns that are not
// blank and do not match a hex digit are flagged and counted.
//
// Ports
//   CLOCK_50   in   1      system clock, rising edge
//   resetn     in   1      asynchronous active-low reset
//   seg_in     in   7      raw pattern, active-low, [0]=a (top) .. [6]=g (middle)
//   out_ready  in   1      consumer takes the offered digit this cycle
//   out_valid  out  1      out_nibble/out_err carry a new digit
//   out_nibble out  4      decoded digit, 0 when out_err=1
//   out_err    out  1      pattern was non-blank and undecodable
//   err_count  out  ERR_W  errored digits emitted, saturating
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_nibble,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned      CNT_W     = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SETTLE      = 2'd0,
    HOLD        = 2'd1,
    WAIT_CHANGE = 2'd2
  } state_e;

  // Returns {legal, nibble}; legal=0 for anything that is not a hex digit.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h10;
      7'h79:   res = 5'h11;
      7'h24:   res = 5'h12;
      7'h30:   res = 5'h13;
      7'h19:   res = 5'h14;
      7'h12:   res = 5'h15;
      7'h02:   res = 5'h16;
      7'h78:   res = 5'h17;
      7'h00:   res = 5'h18;
      7'h10:   res = 5'h19;
      7'h08:   res = 5'h1A;
      7'h03:   res = 5'h1B;
      7'h46:   res = 5'h1C;
      7'h21:   res = 5'h1D;
      7'h06:   res = 5'h1E;
      7'h0E:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       seg_s;
  logic [6:0]       seg_prev_q, seg_prev_d;
  logic [6:0]       captured_q, captured_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]       dec_s;

  assign seg_s = sync2_q;
  assign dec_s = decode_seg(seg_s);

  // Two-flop synchroniser for the asynchronous pattern bus.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
    end
  end

  // State, debounce and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SETTLE;
      seg_prev_q <= SEG_BLANK;
      captured_q <= SEG_BLANK;
      count_q    <= CNT_ZERO;
      valid_q    <= 1'b0;
      nibble_q   <= 4'h0;
      err_q      <= 1'b0;
      err_cnt_q  <= {ERR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      seg_prev_q <= seg_prev_d;
      captured_q <= captured_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      nibble_q   <= nibble_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state logic: debounce in SETTLE, freeze in HOLD, re-arm in WAIT_CHANGE.
  always_comb begin
    state_d    = state_q;
    seg_prev_d = seg_prev_q;
    captured_d = captured_q;
    count_d    = count_q;
    valid_d    = valid_q;
    nibble_d   = nibble_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      SETTLE: begin
        seg_prev_d = seg_s;
        if (seg_s == seg_prev_q) begin
          count_d = (count_q == CNT_MAX) ? CNT_MAX : (count_q + CNT_ONE);
        end else begin
          count_d = CNT_ZERO;
        end
        // Qualification is judged on the count being written this edge so
        // that the digit appears on the same edge the count reaches its limit.
        if (count_d == CNT_MAX) begin
          captured_d = seg_s;
          if (seg_s == SEG_BLANK) begin
            state_d = WAIT_CHANGE;
          end else if (dec_s[4]) begin
            state_d  = HOLD;
            valid_d  = 1'b1;
            nibble_d = dec_s[3:0];
            err_d    = 1'b0;
          end else begin
            state_d  = HOLD;
            valid_d  = 1'b1;
            nibble_d = 4'h0;
            err_d    = 1'b1;
            err_cnt_d = (err_cnt_q == ERR_MAX) ? ERR_MAX : (err_cnt_q + ERR_ONE);
          end
        end else begin
          state_d = SETTLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_CHANGE;
        end else begin
          state_d = HOLD;
        end
      end
      WAIT_CHANGE: begin
        if (seg_s != captured_q) begin
          count_d    = CNT_ZERO;
          seg_prev_d = seg_s;
          state_d    = SETTLE;
        end else begin
          state_d = WAIT_CHANGE;
        end
      end
      default: begin
        state_d = SETTLE;
        valid_d = 1'b0;
        count_d = CNT_ZERO;
      end
    endcase
  end

  assign out_valid  = valid_q;
  assign out_nibble = nibble_q;
  assign out_err    = err_q;
  assign err_count  = err_cnt_q;

endmodule
